vec_data_mem: RTL
=================

VEC_DATA_MEM -- requirements
Module: vec_data_mem

Interface
REQ-001 SHALL have parameter DATA_BUS, default 32, memory data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 1024, number of DATA_BUS-wide words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to ack (range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ld_req  input  1  load request from vec_lsu.
REQ-007 SHALL have port st_req  input  1  store request from vec_lsu.
REQ-008 SHALL have port lsu2mem_addr  input  XLEN(32)  byte address.
REQ-009 SHALL have port lsu2mem_data  input  DATA_BUS  store data.
REQ-010 SHALL have port wr_strobe  input  DATA_BUS/8  byte-lane write enables.
REQ-011 SHALL have port mem2lsu_data  output  DATA_BUS  load data returned to vec_lsu.
REQ-012 SHALL have port mem_ack  output  1  one-cycle response pulse.
REQ-013 SHALL have port mem_busy  output  1  high while a request is outstanding.
REQ-014 SHALL have port addr_err  output  1  error flag, valid with mem_ack.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; requests are sampled only in IDLE.
REQ-016 In IDLE, (ld_req | st_req) SHALL capture addr, data, strobe and type, load a latency counter with LATENCY-1, and go to WAIT; with LATENCY=1, go directly to RESP.
REQ-017 WAIT SHALL decrement the counter each cycle and enter RESP when the counter reaches 0. Ack SHALL occur exactly LATENCY cycles after the acceptance edge.
REQ-018 mem_ack SHALL be registered and high only in RESP; mem_busy SHALL be high in WAIT and RESP.
REQ-019 Word index SHALL be lsu2mem_addr[log2(DEPTH)+log2(DATA_BUS/8)-1 : log2(DATA_BUS/8)]; byte-offset bits SHALL be ignored.
REQ-020 Any nonzero address bit above the index SHALL set addr_err with mem_ack, suppress the write, and return read data 0.
REQ-021 ld_req and st_req both high at acceptance SHALL set addr_err with mem_ack and SHALL NOT access memory.
REQ-022 A store SHALL write only byte lanes with wr_strobe[i]=1, on the edge entering RESP; wr_strobe=0 SHALL produce ack with no write.
REQ-023 A load SHALL capture the array word into mem2lsu_data on the edge entering RESP. mem2lsu_data SHALL hold until the next load ack.
REQ-024 A store SHALL leave mem2lsu_data unchanged.
REQ-025 A request still high in the cycle after RESP (IDLE) SHALL be accepted as a new request. Peak throughput is one access per LATENCY+1 cycles.
REQ-026 Request inputs changing during WAIT/RESP SHALL have no effect.
REQ-027 A load accepted after a store ack SHALL observe the stored bytes (no stale data).

Reset
REQ-028 n_rst low SHALL immediately force IDLE, counter 0, mem_ack 0, mem_busy 0, addr_err 0, mem2lsu_data 0.
REQ-029 Reset mid-operation SHALL drop the outstanding request without ack; an uncommitted store SHALL NOT be written.
REQ-030 The memory array SHALL NOT be reset; contents are undefined until written.

Structure
REQ-031 The state enum and the LATENCY/DEPTH defaults SHALL live in the shared vector-processor package; XLEN and DATA_BUS SHALL come from the existing defines.
REQ-032 The byte-strobed storage SHALL be one sub-module, vec_mem_array (sync write with per-byte enables, registered read). The FSM and counter SHALL stay in vec_data_mem.

Verification (DATA_BUS=32, DEPTH=1024, LATENCY=2)
REQ-033 Store/load: store addr 0x10, data 0xDEADBEEF, strobe 4'hF, then load 0x10 -> each ack exactly 2 cycles after acceptance; load returns 0xDEADBEEF, addr_err=0.
REQ-034 Partial strobe: preload 0x11223344 at 0x20, store 0xAABBCCDD strobe 4'b0101, then load -> 0x11BB33DD.
REQ-035 Errors:
- load 0x0000_1000 (index out of range) -> ack with addr_err=1, mem2lsu_data=0, memory unchanged.
- ld_req=st_req=1 -> ack with addr_err=1, no write.
REQ-036 Back-to-back: hold ld_req high for 9 cycles -> 3 acks, spaced 3 cycles apart; mem_busy low only in the IDLE cycles.
REQ-037 Reset: assert n_rst low one cycle after accepting a store to 0x30 of 0x12345678 -> no ack, all outputs 0; a later load of 0x30 returns the prior contents, not 0x12345678.

Source files
------------

// File: rtl/vec_data_mem_pkg.sv
// Shared definitions for the vector-processor data memory: bus widths,
// default geometry and the request FSM state type.
package vec_data_mem_pkg;

  // Architectural address width and default memory data bus width.
  localparam int unsigned XLEN         = 32;
  localparam int unsigned VEC_DATA_BUS = 32;

  // Default memory geometry and access latency.
  localparam int unsigned VEC_DEPTH    = 1024;
  localparam int unsigned VEC_LATENCY  = 2;

  // Latency counter width; holds LATENCY-1 for LATENCY up to 15.
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mem_state_e;

endpackage

// File: rtl/vec_mem_array.sv
// Byte-strobed word storage: synchronous write with per-byte enables and a
// registered read port. The storage itself has no reset; only the read
// register does, so the load-data output starts at zero.
module vec_mem_array #(
  parameter int unsigned DATA_BUS = 32,
  parameter int unsigned DEPTH    = 1024,
  localparam int unsigned IDX_W   = $clog2(DEPTH),
  localparam int unsigned LANES   = DATA_BUS / 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                we,
  input  logic                re,
  input  logic                clr,
  input  logic [LANES-1:0]    be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_BUS-1:0] wdata,
  output logic [DATA_BUS-1:0] rdata
);

  logic [DATA_BUS-1:0] mem [DEPTH];

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read register: loads on a read, zeroes on an errored load, else holds.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/vec_data_mem.sv
// Vector data memory front end. Accepts one load or store at a time from the
// LSU, waits a fixed LATENCY, then performs the access and pulses mem_ack.
// Address range and load/store conflicts are flagged with addr_err.
module vec_data_mem
  import vec_data_mem_pkg::*;
#(
  parameter int unsigned DATA_BUS = VEC_DATA_BUS,
  parameter int unsigned DEPTH    = VEC_DEPTH,
  parameter int unsigned LATENCY  = VEC_LATENCY
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  ld_req,
  input  logic                  st_req,
  input  logic [XLEN-1:0]       lsu2mem_addr,
  input  logic [DATA_BUS-1:0]   lsu2mem_data,
  input  logic [DATA_BUS/8-1:0] wr_strobe,
  output logic [DATA_BUS-1:0]   mem2lsu_data,
  output logic                  mem_ack,
  output logic                  mem_busy,
  output logic                  addr_err
);

  localparam int unsigned LANES  = DATA_BUS / 8;
  localparam int unsigned OFF_W  = $clog2(LANES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned IDX_HI = IDX_W + OFF_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  mem_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_BUS-1:0] data_q;
  logic [LANES-1:0]    strb_q;
  logic                store_q;
  logic                err_q;

  logic                req;
  logic                req_err;
  logic                req_store;
  logic [IDX_W-1:0]    req_idx;

  logic                enter_resp;
  logic [IDX_W-1:0]    acc_idx;
  logic [DATA_BUS-1:0] acc_data;
  logic [LANES-1:0]    acc_strb;
  logic                acc_store;
  logic                acc_err;
  logic                arr_we;
  logic                arr_re;
  logic                arr_clr;

  // Decode of the live request; byte-offset bits are simply not used.
  assign req       = ld_req | st_req;
  assign req_store = st_req & ~ld_req;
  assign req_idx   = lsu2mem_addr[IDX_HI-1:OFF_W];
  assign req_err   = (ld_req & st_req) | ((lsu2mem_addr >> IDX_HI) != '0);

  // Select the access fields and detect the edge that enters RESP. With
  // LATENCY=1 that edge is the acceptance edge, so the live inputs are used.
  always_comb begin
    enter_resp = 1'b0;
    acc_idx    = idx_q;
    acc_data   = data_q;
    acc_strb   = strb_q;
    acc_store  = store_q;
    acc_err    = err_q;
    if (state_q == StIdle) begin
      acc_idx    = req_idx;
      acc_data   = lsu2mem_data;
      acc_strb   = wr_strobe;
      acc_store  = req_store;
      acc_err    = req_err;
      enter_resp = req && (LATENCY == 1);
    end else if (state_q == StWait) begin
      enter_resp = (cnt_q == CNT_W'(1));
    end
    arr_we  = enter_resp & acc_store & ~acc_err;
    arr_re  = enter_resp & ~acc_store & ~acc_err;
    arr_clr = enter_resp & ~acc_store & acc_err;
  end

  // Request FSM, latency counter, captured request and registered status.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      mem_ack  <= 1'b0;
      mem_busy <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      mem_ack  <= enter_resp;
      addr_err <= enter_resp & acc_err;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q    <= req_idx;
            data_q   <= lsu2mem_data;
            strb_q   <= wr_strobe;
            store_q  <= req_store;
            err_q    <= req_err;
            cnt_q    <= CNT_INIT;
            mem_busy <= 1'b1;
            state_q  <= (LATENCY == 1) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          mem_busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          mem_busy <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  vec_mem_array #(
    .DATA_BUS (DATA_BUS),
    .DEPTH    (DEPTH)
  ) u_array (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .be    (acc_strb),
    .idx   (acc_idx),
    .wdata (acc_data),
    .rdata (mem2lsu_data)
  );

endmodule
